// File: rtl/fb_write_scheduler_pkg.sv
// Shared constants for the frame-buffer write scheduler: geometry defaults,
// address/coordinate widths and the scheduler state encoding.
package fb_write_scheduler_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int BRUSH_DEF = 10;

  localparam int ADDR_W  = 19;
  // Coordinates carry one extra bit so a stamp corner plus brush offset never wraps.
  localparam int COORD_W = 11;
  localparam int CNT_W   = 10;

  typedef logic [1:0] state_t;

  localparam state_t ST_CLEAR = 2'd0;
  localparam state_t ST_IDLE  = 2'd1;
  localparam state_t ST_STAMP = 2'd2;
  localparam state_t ST_HOST  = 2'd3;

endpackage

// File: rtl/fb_write_scheduler_addr_calc.sv
// Converts (row, col) or a raw linear address into a frame-buffer address and
// flags whether that pixel lies inside the H_RES x V_RES frame.
module fb_addr_calc
  import fb_write_scheduler_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic               sel_linear,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic [ADDR_W-1:0]  lin_addr,
  output logic [ADDR_W-1:0]  addr,
  output logic               in_range
);

  localparam logic [31:0] PIXELS = 32'(H_RES * V_RES);
  localparam logic [31:0] H_LIM  = 32'(H_RES);

  logic [31:0] lin;

  // The wide product keeps out-of-frame coordinates from aliasing into the frame;
  // with col < H_RES, lin < PIXELS also implies row < V_RES.
  always_comb begin
    if (sel_linear) begin
      lin = {{(32 - ADDR_W){1'b0}}, lin_addr};
    end else begin
      lin = 32'(row) * H_LIM + 32'(col);
    end
    addr     = lin[ADDR_W-1:0];
    in_range = (lin < PIXELS) && (sel_linear || (32'(col) < H_LIM));
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Single-port frame-buffer write arbiter: full clear after reset or on request,
// BRUSH x BRUSH stamps with edge clipping, and single-pixel host writes.
module fb_write_scheduler
  import fb_write_scheduler_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int BRUSH = BRUSH_DEF
) (
  input  logic              iCLK,
  input  logic              iRSTn,
  input  logic              iCLR_REQ,
  input  logic              iSTAMP_REQ,
  input  logic [9:0]        iSTAMP_X,
  input  logic [9:0]        iSTAMP_Y,
  input  logic              iSTAMP_DATA,
  output logic              oSTAMP_ACK,
  input  logic              iHOST_REQ,
  input  logic [ADDR_W-1:0] iHOST_ADDR,
  input  logic              iHOST_DATA,
  output logic              oHOST_GNT,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic              oWR_DATA,
  output logic              oWR_EN,
  output logic              oBUSY,
  output logic              oCLR_DONE
);

  localparam logic [CNT_W-1:0] CLR_COL_LAST = CNT_W'(H_RES - 1);
  localparam logic [CNT_W-1:0] CLR_ROW_LAST = CNT_W'(V_RES - 1);
  localparam logic [CNT_W-1:0] STAMP_LAST   = CNT_W'(BRUSH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t             state;
  logic [CNT_W-1:0]   row_cnt;
  logic [CNT_W-1:0]   col_cnt;
  logic [9:0]         stamp_x;
  logic [9:0]         stamp_y;
  logic               stamp_data;

  logic               calc_linear;
  logic [COORD_W-1:0] calc_row;
  logic [COORD_W-1:0] calc_col;
  logic [ADDR_W-1:0]  calc_addr;
  logic               calc_in_range;
  logic               col_last;
  logic               row_last;

  // The raster counters are absolute coordinates while clearing and offsets from
  // the latched corner while stamping.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    calc_linear = (state == ST_HOST);
    calc_row    = COORD_W'(row_cnt);
    calc_col    = COORD_W'(col_cnt);
    col_last    = (col_cnt == CLR_COL_LAST);
    row_last    = (row_cnt == CLR_ROW_LAST);
    if (state == ST_STAMP) begin
      calc_row = COORD_W'(stamp_y) + COORD_W'(row_cnt);
      calc_col = COORD_W'(stamp_x) + COORD_W'(col_cnt);
      col_last = (col_cnt == STAMP_LAST);
      row_last = (row_cnt == STAMP_LAST);
    end
  end

  fb_addr_calc #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_addr_calc (
    .sel_linear (calc_linear),
    .row        (calc_row),
    .col        (calc_col),
    .lin_addr   (iHOST_ADDR),
    .addr       (calc_addr),
    .in_range   (calc_in_range)
  );

  assign oBUSY = (state != ST_IDLE);

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state      <= ST_CLEAR;
      row_cnt    <= '0;
      col_cnt    <= '0;
      stamp_x    <= '0;
      stamp_y    <= '0;
      stamp_data <= 1'b0;
      oWR_ADDR   <= '0;
      oWR_DATA   <= 1'b0;
      oWR_EN     <= 1'b0;
      oSTAMP_ACK <= 1'b0;
      oHOST_GNT  <= 1'b0;
      oCLR_DONE  <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here make every pulse last exactly one cycle;
      // later assignments in the same block override them.
      oWR_EN     <= 1'b0;
      oSTAMP_ACK <= 1'b0;
      oHOST_GNT  <= 1'b0;
      oCLR_DONE  <= 1'b0;

      case (state)
        ST_CLEAR, ST_STAMP: begin
          oWR_ADDR <= calc_addr;
          if (state == ST_CLEAR) begin
            oWR_EN   <= 1'b1;
            oWR_DATA <= 1'b0;
          end else begin
            oWR_EN   <= calc_in_range;
            oWR_DATA <= stamp_data;
          end
          if (col_last) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + CNT_ONE;
            if (row_last) begin
              row_cnt    <= '0;
              state      <= ST_IDLE;
              oCLR_DONE  <= (state == ST_CLEAR);
              oSTAMP_ACK <= (state == ST_STAMP);
            end
          end else begin
            col_cnt <= col_cnt + CNT_ONE;
          end
        end

        ST_IDLE: begin
          row_cnt <= '0;
          col_cnt <= '0;
          if (iCLR_REQ) begin
            state <= ST_CLEAR;
          end else if (iSTAMP_REQ) begin
            state      <= ST_STAMP;
            stamp_x    <= iSTAMP_X;
            stamp_y    <= iSTAMP_Y;
            stamp_data <= iSTAMP_DATA;
          end else if (iHOST_REQ) begin
            state <= ST_HOST;
          end
        end

        ST_HOST: begin
          oWR_ADDR  <= calc_addr;
          oWR_DATA  <= iHOST_DATA;
          oWR_EN    <= calc_in_range;
          oHOST_GNT <= 1'b1;
          state     <= ST_IDLE;
        end

        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Scoreboard bench for fb_write_scheduler on a reduced 40x30 frame: a driver
// queues expected write-port records, a monitor pops and compares each one.
module tb_fb_write_scheduler;

  localparam int H   = 40;
  localparam int V   = 30;
  localparam int B   = 10;
  localparam int PIX = H * V;
  localparam int AW  = 19;

  localparam int P_ACK  = 0;
  localparam int P_GNT  = 1;
  localparam int P_DONE = 2;

  typedef struct packed {
    logic          en;
    logic          chk_addr;
    logic [AW-1:0] addr;
    logic          data;
    logic          ack;
    logic          gnt;
    logic          done;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_req = 1'b0;
  logic          stamp_req = 1'b0;
  logic [9:0]    stamp_x = '0;
  logic [9:0]    stamp_y = '0;
  logic          stamp_data = 1'b0;
  logic          host_req = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic          host_data = 1'b0;
  logic          stamp_ack;
  logic          host_gnt;
  logic [AW-1:0] wr_addr;
  logic          wr_data;
  logic          wr_en;
  logic          busy;
  logic          clr_done;

  int   checks = 0;
  int   errors = 0;
  int   wr_seen = 0;
  exp_t exp_q[$];

  fb_write_scheduler #(
    .H_RES (H),
    .V_RES (V),
    .BRUSH (B)
  ) dut (
    .iCLK        (clk),
    .iRSTn       (rst_n),
    .iCLR_REQ    (clr_req),
    .iSTAMP_REQ  (stamp_req),
    .iSTAMP_X    (stamp_x),
    .iSTAMP_Y    (stamp_y),
    .iSTAMP_DATA (stamp_data),
    .oSTAMP_ACK  (stamp_ack),
    .iHOST_REQ   (host_req),
    .iHOST_ADDR  (host_addr),
    .iHOST_DATA  (host_data),
    .oHOST_GNT   (host_gnt),
    .oWR_ADDR    (wr_addr),
    .oWR_DATA    (wr_data),
    .oWR_EN      (wr_en),
    .oBUSY       (busy),
    .oCLR_DONE   (clr_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(bit en, bit chk, int addr, bit data, bit ack, bit gnt, bit done);
    exp_t e;
    e.en       = en;
    e.chk_addr = chk;
    e.addr     = AW'(addr);
    e.data     = data;
    e.ack      = ack;
    e.gnt      = gnt;
    e.done     = done;
    return e;
  endfunction

  // Reference model: what the write port must show, one record per active cycle.
  task automatic push_clear();
    for (int a = 0; a < PIX; a++) exp_q.push_back(mk(1, 1, a, 0, 0, 0, a == PIX - 1));
  endtask

  task automatic push_stamp(input int x, input int y, input bit d);
    for (int r = 0; r < B; r++) begin
      for (int c = 0; c < B; c++) begin
        int  col;
        int  row;
        bit  inr;
        bit  last;
        col  = x + c;
        row  = y + r;
        inr  = (col < H) && (row < V);
        last = (r == B - 1) && (c == B - 1);
        if (inr || last) exp_q.push_back(mk(inr, inr, row * H + col, d, last, 0, 0));
      end
    end
  endtask

  task automatic push_host(input int a, input bit d);
    exp_q.push_back(mk(a < PIX, 1, a, d, 0, 1, 0));
  endtask

  // Monitor: every cycle with any write-port activity consumes one expected record.
  initial begin : monitor
    exp_t        e;
    logic [23:0] act;
    logic [23:0] want;
    forever begin
      @(negedge clk);
      if (rst_n && (wr_en || stamp_ack || host_gnt || clr_done)) begin
        if (wr_en) wr_seen++;
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'({clr_done, host_gnt, stamp_ack, wr_en, wr_data, wr_addr}), 32'd0);
        end else begin
          e    = exp_q.pop_front();
          act  = {clr_done, host_gnt, stamp_ack, wr_en, wr_data & e.en,
                  e.chk_addr ? wr_addr : {AW{1'b0}}};
          want = {e.done, e.gnt, e.ack, e.en, e.data & e.en,
                  e.chk_addr ? e.addr : {AW{1'b0}}};
          check("wr_rec", 32'(act), 32'(want));
        end
      end
    end
  end

  // Waits for a completion pulse, dropping the matching request in that same cycle.
  task automatic wait_pulse(input int which, input int budget, output int n);
    bit seen;
    n    = 0;
    seen = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      case (which)
        P_ACK:   seen = stamp_ack;
        P_GNT:   seen = host_gnt;
        default: seen = clr_done;
      endcase
    end
    if (seen) begin
      case (which)
        P_ACK:   stamp_req = 1'b0;
        P_GNT:   host_req  = 1'b0;
        default: clr_req   = 1'b0;
      endcase
    end
    check($sformatf("pulse%0d_seen", which), 32'(seen), 32'd1);
  endtask

  task automatic issue_stamp(input int x, input int y, input bit d, input string tag,
                             output int writes);
    int n;
    int w0;
    @(negedge clk);
    w0 = wr_seen;
    push_stamp(x, y, d);
    stamp_x    = 10'(x);
    stamp_y    = 10'(y);
    stamp_data = d;
    stamp_req  = 1'b1;
    @(negedge clk);
    // Inputs wander after acceptance; the latched corner and data must hold.
    stamp_x    = 10'($urandom);
    stamp_y    = 10'($urandom);
    stamp_data = ~d;
    wait_pulse(P_ACK, B * B + 20, n);
    check({tag, "_cycles"}, 32'(n + 1), 32'(B * B + 1));
    #1 writes = wr_seen - w0;
  endtask

  task automatic issue_host(input int a, input bit d);
    int n;
    @(negedge clk);
    push_host(a, d);
    host_addr = AW'(a);
    host_data = d;
    host_req  = 1'b1;
    wait_pulse(P_GNT, 10, n);
    check("host_cycles", 32'(n), 32'd2);
  endtask

  initial begin : driver
    int n;
    int w;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_ack", 32'(stamp_ack), 32'd0);
    check("rst_gnt", 32'(host_gnt), 32'd0);
    check("rst_done", 32'(clr_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);

    push_clear();
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_pulse(P_DONE, PIX + 20, n);
    check("boot_clear_cycles", 32'(n), 32'(PIX + 1));
    check("busy_after_clear", 32'(busy), 32'd0);
    @(negedge clk);
    check("clr_done_single", 32'(clr_done), 32'd0);

    issue_stamp(12, 8, 1'b1, "stamp_inner", w);
    check("stamp_inner_writes", 32'(w), 32'(B * B));
    issue_stamp(H - 5, V - 5, 1'b1, "stamp_corner", w);
    check("stamp_corner_writes", 32'(w), 32'd25);
    issue_stamp(1000, 5, 1'b0, "stamp_offscreen", w);
    check("stamp_offscreen_writes", 32'(w), 32'd0);

    issue_host(777, 1'b1);
    issue_host(PIX - 1, 1'b1);
    issue_host(PIX, 1'b1);

    // Stamp and host together: stamp wins, host follows.
    @(negedge clk);
    push_stamp(3, 4, 1'b1);
    push_host(50, 1'b1);
    stamp_x = 10'd3; stamp_y = 10'd4; stamp_data = 1'b1; stamp_req = 1'b1;
    host_addr = AW'(50); host_data = 1'b1; host_req = 1'b1;
    wait_pulse(P_ACK, B * B + 20, n);
    check("pair_stamp_cycles", 32'(n), 32'(B * B + 1));
    wait_pulse(P_GNT, 10, n);
    check("pair_host_cycles", 32'(n), 32'd2);

    // All three at once: clear, then stamp, then host.
    @(negedge clk);
    push_clear();
    push_stamp(30, 0, 1'b0);
    push_host(5, 1'b0);
    clr_req = 1'b1;
    stamp_x = 10'd30; stamp_y = 10'd0; stamp_data = 1'b0; stamp_req = 1'b1;
    host_addr = AW'(5); host_data = 1'b0; host_req = 1'b1;
    wait_pulse(P_DONE, PIX + 20, n);
    check("tri_clear_cycles", 32'(n), 32'(PIX + 1));
    wait_pulse(P_ACK, B * B + 20, n);
    check("tri_stamp_cycles", 32'(n), 32'(B * B + 1));
    wait_pulse(P_GNT, 10, n);
    check("tri_host_cycles", 32'(n), 32'd2);

    // Clear requested mid-stamp must wait for the stamp to finish.
    @(negedge clk);
    push_stamp(20, 20, 1'b1);
    push_clear();
    stamp_x = 10'd20; stamp_y = 10'd20; stamp_data = 1'b1; stamp_req = 1'b1;
    repeat (50) @(negedge clk);
    clr_req = 1'b1;
    wait_pulse(P_ACK, B * B, n);
    check("late_clr_stamp_cycles", 32'(n + 50), 32'(B * B + 1));
    wait_pulse(P_DONE, PIX + 20, n);
    check("late_clr_clear_cycles", 32'(n), 32'(PIX + 1));

    // Reset mid-stamp: no ack, and a fresh clear from address 0.
    @(negedge clk);
    push_stamp(5, 5, 1'b1);
    stamp_x = 10'd5; stamp_y = 10'd5; stamp_data = 1'b1; stamp_req = 1'b1;
    repeat (30) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    stamp_req = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_ack", 32'(stamp_ack), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    push_clear();
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_pulse(P_DONE, PIX + 20, n);
    check("midrst_clear_cycles", 32'(n), 32'(PIX + 1));

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        int x;
        int y;
        x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, H + 2));
        y = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, V + 2));
        issue_stamp(x, y, 1'($urandom), "rand_stamp", w);
      end else begin
        int a;
        a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, (1 << AW) - 1))
                                        : int'($urandom_range(0, PIX + 20));
        issue_host(a, 1'($urandom));
      end
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fb_write_scheduler.md
FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

Interface
REQ-001 Parameter H_RES, default 640, frame buffer width in pixels.
REQ-002 Parameter V_RES, default 480, frame buffer height in pixels.
REQ-003 Parameter BRUSH, default 10, square stamp edge in pixels.
REQ-004 One clock, iCLK; reset iRSTn is asynchronous and active-low.
REQ-005 iCLK  in  1  pixel clock (25 MHz domain).
REQ-006 iRSTn  in  1  async active-low reset.
REQ-007 iCLR_REQ  in  1  level; request a full-frame clear to 0.
REQ-008 iSTAMP_REQ  in  1  level; request a BRUSHxBRUSH stamp.
REQ-009 iSTAMP_X, iSTAMP_Y  in  10 each  stamp top-left corner.
REQ-010 iSTAMP_DATA  in  1  pixel value for the stamp (1 draw, 0 erase).
REQ-011 oSTAMP_ACK  out  1  one-cycle pulse when a stamp completes.
REQ-012 iHOST_REQ  in  1  level; single-pixel write request.
REQ-013 iHOST_ADDR  in  19  linear pixel address; iHOST_DATA  in  1  pixel value.
REQ-014 oHOST_GNT  out  1  one-cycle pulse in the cycle the host write is issued.
REQ-015 oWR_ADDR  out  19, oWR_DATA  out  1, oWR_EN  out  1  frame-buffer write port.
REQ-016 oBUSY  out  1  high in any state other than IDLE; oCLR_DONE  out  1  one-cycle pulse at end of clear.

Function
REQ-017 States: CLEAR, IDLE, STAMP, HOST; all write-port outputs registered.
REQ-018 Write address = row*H_RES + col, computed at 19 bits with no truncation.
REQ-019 CLEAR: writes 0 to addresses 0..H_RES*V_RES-1 ascending, one per cycle, oWR_EN=1; then oCLR_DONE pulse and go to IDLE.
REQ-020 IDLE priority: iCLR_REQ > iSTAMP_REQ > iHOST_REQ; oWR_EN=0 while in IDLE.
REQ-021 Stamp acceptance latches iSTAMP_X, iSTAMP_Y, iSTAMP_DATA; later changes are ignored until oSTAMP_ACK.
REQ-022 STAMP: exactly BRUSH*BRUSH cycles, raster order (column inner, row outer), starting at the latched corner.
REQ-023 A stamp pixel with col>=H_RES or row>=V_RES is clipped: the cycle is consumed with oWR_EN=0.
REQ-024 oSTAMP_ACK pulses in the cycle after the last stamp pixel; the state returns to IDLE in that same cycle.
REQ-025 HOST: one cycle; oWR_ADDR=iHOST_ADDR, oWR_DATA=iHOST_DATA, oWR_EN=1, oHOST_GNT=1; then IDLE.
REQ-026 A host address >= H_RES*V_RES is granted with oWR_EN=0.
REQ-027 No preemption: a clear or stamp request arriving during STAMP or CLEAR waits until the current operation finishes.
REQ-028 A request still held after its ack/grant is treated as a new request.
REQ-029 Output latency: a write decision made in cycle N appears on oWR_* in cycle N+1.

Reset
REQ-030 On reset: state=CLEAR, counters=0, oWR_EN=0, oWR_DATA=0, oWR_ADDR=0, oSTAMP_ACK=0, oHOST_GNT=0, oCLR_DONE=0, oBUSY=1.
REQ-031 Reset asserted mid-operation aborts that operation without an ack; a full clear restarts after release.

Structure
REQ-032 A shared package holds the H_RES/V_RES/BRUSH defaults, the state encoding, and the address width (19).
REQ-033 One sub-module, fb_addr_calc (row, col -> linear address plus in-range flag), is used by CLEAR, STAMP and HOST.

Verification
REQ-034 Reset release -> 307200 consecutive writes of 0, addresses 0..307199, then a single oCLR_DONE pulse and oBUSY=0.
REQ-035 Stamp at (200,200), data 1 -> 100 writes, first address 128200, last address 133969, then one oSTAMP_ACK pulse.
REQ-036 Stamp at (635,475) -> 100 cycles with exactly 25 enabled writes (cols 635..639, rows 475..479).
REQ-037 iSTAMP_REQ and iHOST_REQ raised together in IDLE -> full stamp first, then oHOST_GNT with a single write to iHOST_ADDR.
REQ-038 iCLR_REQ raised in stamp cycle 50 -> stamp completes and acks, then a full clear runs.
REQ-039 iRSTn pulsed low in stamp cycle 30 -> no oSTAMP_ACK, and a clear restarts from address 0.
